parity_counter_nbit_dft: RTL and testbench
==========================================

// Module: parity_counter_nbit_dft
// PURPOSE
//  Parametrised up/down counter with all/even/odd stepping, a programmable wrap
//  limit and a full scan chain through the count register.
//  Drives a time-multiplexed hex 7-segment display, one digit per nibble of Q.
//  Sits between debounced front-panel switches and the board display.
// PARAMETERS
//  WIDTH           8              count width in bits, >= 2
//  MAX_VAL         2**WIDTH-1     highest count value, 1..2**WIDTH-1
//  REFRESH_DIV     1000           CLK cycles each display digit stays selected, >= 1
//  SEG_ACTIVE_LOW  0              1 = invert SEG and DIG outputs
//  localparam NUM_DIGITS = (WIDTH+3)/4
// PORTS
//  CLK          in   1           clock, rising edge
//  RESET        in   1           reset, synchronous, active-high
//  EVEN         in   1           even-mode select
//  ODD          in   1           odd-mode select
//  UP_DN        in   1           1 = count up, 0 = count down
//  PAUSE        in   1           hold Q
//  SCAN_ENABLE  in   1           1 = shift mode
//  SCAN_IN      in   1           scan data in
//  SCAN_OUT     out  1           scan data out = Q[WIDTH-1]
//  Q            out  WIDTH       registered count
//  WRAP         out  1           one-cycle pulse when a step wraps
//  SEG          out  7           {a,b,c,d,e,f,g}; 1 = lit when SEG_ACTIVE_LOW=0
//  DIG          out  NUM_DIGITS  one-hot digit enable; bit 0 = least-significant nibble
// BEHAVIOUR
//  Reset values: Q=0, WRAP=0, digit select=0 (DIG=...0001), refresh count=0.
//   SEG decodes nibble 0 of Q, so SEG shows "0" (7'b1111110) after reset.
//  Priority per edge: RESET > SCAN_ENABLE > PAUSE > count.
//  Scan: Q <= {Q[WIDTH-2:0],SCAN_IN}; WRAP <= 0; the display keeps refreshing.
//   After WIDTH shift cycles the chain holds exactly the shifted-in Q.
//  Pause: Q holds; WRAP <= 0.
//  Mode: EVEN==ODD -> ALL (step 1); ODD only -> ODD set; EVEN only -> EVEN set.
//   In ODD/EVEN mode the legal set is the values of that parity in 0..MAX_VAL.
//   lo = 1 for ODD, else 0.
//   hi = the largest legal value <= MAX_VAL.
//  Step: if Q is legal for the mode, step = 2; if Q is illegal (e.g. after a
//   mode change), step = 1 to realign. ALL mode: step = 1.
//  Up: n = Q+step, computed WIDTH+1 bits wide. If n > hi: Q <= lo and WRAP <= 1.
//   Otherwise Q <= n.
//  Down: if Q < lo+step: Q <= hi and WRAP <= 1. Otherwise Q <= Q-step.
//  If Q > MAX_VAL (possible via scan), the next count step wraps as if the
//   limit was exceeded: up -> lo, down -> hi, WRAP=1.
//  Latency: a change on EVEN/ODD/UP_DN/PAUSE takes effect at the next edge.
//  Display: the refresh counter counts 0..REFRESH_DIV-1, then the digit select
//   advances and wraps at NUM_DIGITS-1.
//   SEG is combinational from Q nibble[sel]; upper bits of a partial nibble
//   read as 0. Hex glyphs 0-F. Encodings 0-7 match the team's existing decoder.
//  RESET asserted mid-scan or mid-count: the next edge gives the reset values.
// STRUCTURE
//  Shared package parity_counter_pkg:
//   - typedef count_mode_t {MODE_ALL, MODE_EVEN, MODE_ODD}
//   - function hex_to_seg7(logic [3:0]) -> logic [6:0]
//   - constant SEG_BLANK = 7'b0000000
//  One sub-module, seg7_digit_mux: refresh counter, digit select, nibble
//   select, decode, polarity.
//  The core counter, mode/legal/wrap logic and scan live in the top module.
// TESTING (WIDTH=4, MAX_VAL=9, REFRESH_DIV=2 unless noted)
//  1 RESET=1 for one edge from any state -> Q=0, WRAP=0, DIG=1, SEG=7'b1111110.
//  2 ALL mode, up, 10 edges from 0 -> 1..9 then 0; WRAP=1 only on the 9->0 edge.
//  3 ODD up from Q=4 -> 5,7,9,1 (WRAP on 9->1).
//    EVEN down from Q=0 -> 8 (WRAP=1), then 6,4.
//  4 PAUSE=1 mid-count for 3 edges -> Q frozen, WRAP=0.
//    SCAN_ENABLE together with PAUSE -> shift happens.
//  5 Scan: shift 1,0,1,1 -> Q=4'b1011 (11 > MAX_VAL).
//    SCAN_OUT must show the old Q MSB-first.
//    Release scan, ALL up -> Q=0, WRAP=1.
//  6 WIDTH=8, MAX_VAL=255, Q=8'hA5 -> DIG alternates 01/10 every 2 cycles.
//    SEG shows 5 (7'b1011011), then A (7'b1110111).

Source files
------------

// File: rtl/parity_counter_pkg.sv
// Shared types and the hex glyph decoder for the parity counter block.
package parity_counter_pkg;

  typedef enum logic [1:0] {
    MODE_ALL  = 2'd0,
    MODE_EVEN = 2'd1,
    MODE_ODD  = 2'd2
  } count_mode_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Hex nibble to {a,b,c,d,e,f,g}, 1 = segment lit
  function automatic logic [6:0] hex_to_seg7(input logic [3:0] nib);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      4'hF: seg = 7'b1000111;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/parity_counter_nbit_dft_seg7_digit_mux.sv
// Time-multiplexed hex display driver: one digit per nibble of q.
module seg7_digit_mux
  import parity_counter_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned REFRESH_DIV    = 1000,
  parameter int unsigned SEG_ACTIVE_LOW = 0,
  parameter int unsigned NUM_DIGITS     = (WIDTH + 3) / 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      q,
  output logic [6:0]            seg_c,
  output logic [NUM_DIGITS-1:0] dig_c
);

  localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PAD_W = NUM_DIGITS * 4;

  logic [REF_W-1:0]      refresh_cnt;
  logic [SEL_W-1:0]      sel;
  logic [PAD_W-1:0]      q_pad;
  logic [3:0]            nibble;
  logic [NUM_DIGITS-1:0] dig_raw;

  // Partial top nibble reads its missing bits as zero
  assign q_pad = PAD_W'(q);

  // Refresh divider and digit select
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      sel         <= '0;
    end else if (refresh_cnt == REF_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      sel         <= (sel == SEL_W'(NUM_DIGITS - 1)) ? '0 : sel + SEL_W'(1);
    end else begin
      refresh_cnt <= refresh_cnt + REF_W'(1);
    end
  end

  // Select the active nibble and its one-hot digit enable
  always_comb begin
    nibble  = '0;
    dig_raw = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel == SEL_W'(i)) begin
        nibble     = q_pad[i*4 +: 4];
        dig_raw[i] = 1'b1;
      end
    end
  end

  assign seg_c = (SEG_ACTIVE_LOW != 0) ? ~hex_to_seg7(nibble) : hex_to_seg7(nibble);
  assign dig_c = (SEG_ACTIVE_LOW != 0) ? ~dig_raw : dig_raw;

endmodule

// File: rtl/parity_counter_nbit_dft.sv
// Up/down counter with all/even/odd stepping, wrap limit, scan chain and hex display.
module parity_counter_nbit_dft
  import parity_counter_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned MAX_VAL        = 2**WIDTH - 1,
  parameter int unsigned REFRESH_DIV    = 1000,
  parameter int unsigned SEG_ACTIVE_LOW = 0,
  localparam int unsigned NUM_DIGITS    = (WIDTH + 3) / 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  EVEN,
  input  logic                  ODD,
  input  logic                  UP_DN,
  input  logic                  PAUSE,
  input  logic                  SCAN_ENABLE,
  input  logic                  SCAN_IN,
  output logic                  SCAN_OUT,
  output logic [WIDTH-1:0]      Q,
  output logic                  WRAP,
  output logic [6:0]            SEG,
  output logic [NUM_DIGITS-1:0] DIG
);

  localparam int unsigned HI_EVEN = (MAX_VAL % 2 == 0) ? MAX_VAL : MAX_VAL - 1;
  localparam int unsigned HI_ODD  = (MAX_VAL % 2 == 1) ? MAX_VAL : MAX_VAL - 1;
  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VAL);

  count_mode_t      mode;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   lo_ext;
  logic [WIDTH:0]   hi_ext;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   up_ext;
  logic             parity_ok;
  logic             legal;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;

  assign q_ext = {1'b0, Q};

  // Mode decode, legal range and step size
  always_comb begin
    if (EVEN == ODD)  mode = MODE_ALL;
    else if (ODD)     mode = MODE_ODD;
    else              mode = MODE_EVEN;

    case (mode)
      MODE_ODD: begin
        lo_ext    = (WIDTH+1)'(1);
        hi_ext    = (WIDTH+1)'(HI_ODD);
        parity_ok = Q[0];
      end
      MODE_EVEN: begin
        lo_ext    = '0;
        hi_ext    = (WIDTH+1)'(HI_EVEN);
        parity_ok = ~Q[0];
      end
      default: begin
        lo_ext    = '0;
        hi_ext    = MAX_EXT;
        parity_ok = 1'b1;
      end
    endcase

    legal    = (q_ext <= MAX_EXT) && parity_ok;
    step_ext = (mode != MODE_ALL && legal) ? (WIDTH+1)'(2) : (WIDTH+1)'(1);
    up_ext   = q_ext + step_ext;
  end

  // Next count: scan shift, hold, or step with wrap
  always_comb begin
    q_next    = Q;
    wrap_next = 1'b0;
    if (SCAN_ENABLE) begin
      q_next = {Q[WIDTH-2:0], SCAN_IN};
    end else if (!PAUSE) begin
      if (q_ext > MAX_EXT) begin
        q_next    = UP_DN ? lo_ext[WIDTH-1:0] : hi_ext[WIDTH-1:0];
        wrap_next = 1'b1;
      end else if (UP_DN) begin
        if (up_ext > hi_ext) begin
          q_next    = lo_ext[WIDTH-1:0];
          wrap_next = 1'b1;
        end else begin
          q_next = up_ext[WIDTH-1:0];
        end
      end else begin
        if (q_ext < lo_ext + step_ext) begin
          q_next    = hi_ext[WIDTH-1:0];
          wrap_next = 1'b1;
        end else begin
          q_next = WIDTH'(q_ext - step_ext);
        end
      end
    end
  end

  // Count register and wrap pulse
  always_ff @(posedge CLK) begin
    if (RESET) begin
      Q    <= '0;
      WRAP <= 1'b0;
    end else begin
      Q    <= q_next;
      WRAP <= wrap_next;
    end
  end

  assign SCAN_OUT = Q[WIDTH-1];

  seg7_digit_mux #(
    .WIDTH          (WIDTH),
    .REFRESH_DIV    (REFRESH_DIV),
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW),
    .NUM_DIGITS     (NUM_DIGITS)
  ) u_display (
    .clk   (CLK),
    .reset (RESET),
    .q     (Q),
    .seg_c (SEG),
    .dig_c (DIG)
  );

endmodule

// File: tb/tb_parity_counter_nbit_dft.sv
// Scoreboard bench: small 4-bit counter (MAX 9) plus an 8-bit instance for the display mux.
module tb_parity_counter_nbit_dft;

  localparam int MAXV = 9;

  logic       clk = 1'b0;
  logic       rst, even, odd, up_dn, pause, se, si;
  logic       so_a;
  logic [3:0] q_a;
  logic       wrap_a;
  logic [6:0] seg_a;
  logic [0:0] dig_a;

  logic       rst_b, se_b, si_b, pause_b;
  logic       zero_b = 1'b0;
  logic       so_b;
  logic [7:0] q_b;
  logic       wrap_b;
  logic [6:0] seg_b;
  logic [1:0] dig_b;

  always #5 clk = ~clk;

  parity_counter_nbit_dft #(.WIDTH(4), .MAX_VAL(9), .REFRESH_DIV(2), .SEG_ACTIVE_LOW(0)) dut_a (
    .CLK(clk), .RESET(rst), .EVEN(even), .ODD(odd), .UP_DN(up_dn), .PAUSE(pause),
    .SCAN_ENABLE(se), .SCAN_IN(si), .SCAN_OUT(so_a), .Q(q_a), .WRAP(wrap_a),
    .SEG(seg_a), .DIG(dig_a));

  parity_counter_nbit_dft #(.WIDTH(8), .MAX_VAL(255), .REFRESH_DIV(2), .SEG_ACTIVE_LOW(0)) dut_b (
    .CLK(clk), .RESET(rst_b), .EVEN(zero_b), .ODD(zero_b), .UP_DN(zero_b), .PAUSE(pause_b),
    .SCAN_ENABLE(se_b), .SCAN_IN(si_b), .SCAN_OUT(so_b), .Q(q_b), .WRAP(wrap_b),
    .SEG(seg_b), .DIG(dig_b));

  logic [6:0] glyph [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  typedef struct {
    int q; int wrap; int dig; int seg; int so;
    int q8; int wrap8; int dig8; int seg8; int so8;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  int mq = 0, mw = 0, mk = 0;
  int mq8 = 0, mw8 = 0, mk8 = 0;
  int bcyc = 0;
  logic [7:0] pat_b = 8'hA5;

  function automatic bit is_legal(int v, int mode);
    if (v > MAXV) return 1'b0;
    if (mode == 0) return 1'b1;
    return (v % 2) == ((mode == 2) ? 1 : 0);
  endfunction

  // Next count = nearest legal value in the step direction, else wrap to the far end
  function automatic void count_step(input int q, input int mode, input bit up,
                                     output int nq, output int w);
    int lo = -1, hi = -1, cand = -1;
    for (int v = 0; v <= MAXV; v++) begin
      if (is_legal(v, mode)) begin
        if (lo < 0) lo = v;
        hi = v;
        if (up && v > q && cand < 0) cand = v;
        if (!up && v < q) cand = v;
      end
    end
    if (q > MAXV || cand < 0) begin
      nq = up ? lo : hi;
      w  = 1;
    end else begin
      nq = cand;
      w  = 0;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, push the expected result
  task automatic cyc(input bit r, input bit e, input bit o, input bit u,
                     input bit p, input bit s, input bit i);
    exp_t ex;
    int   mode, sel8, nib;
    rst = r; even = e; odd = o; up_dn = u; pause = p; se = s; si = i;
    rst_b   = (bcyc < 2);
    se_b    = (bcyc >= 2 && bcyc < 10);
    si_b    = se_b ? pat_b[9 - bcyc] : 1'b0;
    pause_b = 1'b1;
    bcyc++;

    mode = (e == o) ? 0 : (o ? 2 : 1);
    if (r) begin
      mq = 0; mw = 0; mk = 0;
    end else begin
      mk++;
      if (s) begin
        mq = ((mq * 2) + i) % 16; mw = 0;
      end else if (p) begin
        mw = 0;
      end else begin
        count_step(mq, mode, u, mq, mw);
      end
    end

    if (rst_b) begin
      mq8 = 0; mw8 = 0; mk8 = 0;
    end else begin
      mk8++;
      mw8 = 0;
      if (se_b) mq8 = ((mq8 * 2) + si_b) % 256;
    end

    ex.q = mq; ex.wrap = mw; ex.dig = 1; ex.seg = glyph[mq]; ex.so = mq / 8;
    sel8 = (mk8 / 2) % 2;
    nib  = sel8 ? (mq8 / 16) : (mq8 % 16);
    ex.q8 = mq8; ex.wrap8 = mw8; ex.dig8 = sel8 ? 2 : 1; ex.seg8 = glyph[nib];
    ex.so8 = mq8 / 128;
    sb.push_back(ex);
    @(negedge clk);
  endtask

  // Monitor: compare every post-edge output against the oldest expectation
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        ex = sb.pop_front();
        chk("q",         int'(q_a),    ex.q);
        chk("wrap",      int'(wrap_a), ex.wrap);
        chk("dig",       int'(dig_a),  ex.dig);
        chk("seg",       int'(seg_a),  ex.seg);
        chk("scan_out",  int'(so_a),   ex.so);
        chk("q8",        int'(q_b),    ex.q8);
        chk("wrap8",     int'(wrap_b), ex.wrap8);
        chk("dig8",      int'(dig_b),  ex.dig8);
        chk("seg8",      int'(seg_b),  ex.seg8);
        chk("scan_out8", int'(so_b),   ex.so8);
      end
    end
  end

  // Stimulus
  initial begin
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    // ALL up through the 9 -> 0 wrap
    repeat (10) cyc(0, 0, 0, 1, 0, 0, 0);
    // Reach 4, then ODD up: 5,7,9,1
    repeat (4) cyc(0, 0, 0, 1, 0, 0, 0);
    repeat (4) cyc(0, 0, 1, 1, 0, 0, 0);
    // Reset mid-count, then EVEN down: 8 (wrap), 6, 4
    cyc(1, 0, 0, 1, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 0, 0, 0, 0);
    // Pause holds; scan overrides pause
    repeat (2) cyc(0, 0, 0, 1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 1, 1);
    // Shift 1,0,1,1 -> 11 (above limit), then ALL up wraps to 0
    cyc(0, 0, 0, 1, 0, 1, 1);
    cyc(0, 0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 1, 1);
    cyc(0, 0, 0, 1, 0, 1, 1);
    cyc(0, 0, 0, 1, 0, 0, 0);
    // Randomised mix
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 39) == 0,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
